mmo_game_regs: RTL and testbench
================================

// Module: mmo_game_regs
// PURPOSE
//  Avalon-MM slave register block on the HPS-side exported master bus (o_mmo_*) of the game SoC.
//  Provides ID, control/status, a down-counting game-tick timer, a saturating score register, and a
//  FIFO of display words drained by fabric-side display logic through a valid/ready handshake.
//  The bus carries no waitrequest: every access completes in one cycle; read latency is fixed at 1.
// PARAMETERS
//  FIFO_AW   3             log2 of display FIFO depth (depth = 2**FIFO_AW = 8)
//  ID_VALUE  32'h47414D45  constant returned by ID register ("GAME")
// PORTS
//  clk            in   1   system clock (driven by clk_o_clk)
//  reset          in   1   asynchronous, active-high reset (driven by reset_o_reset)
//  mmo_write      in   1   bus write strobe
//  mmo_read       in   1   bus read strobe
//  mmo_address    in   5   word address
//  mmo_writedata  in   32  write data
//  mmo_byteenable in   4   byte lanes for CTRL/RELOAD/SCORE writes
//  mmo_readdata   out  32  read data, valid cycle after mmo_read
//  disp_data      out  32  FIFO head word (show-ahead)
//  disp_valid     out  1   FIFO non-empty
//  disp_ready     in   1   consumer accepts disp_data this cycle
//  irq            out  1   interrupt (present only with GAME_IRQ_EN)
// BEHAVIOUR
//  Reset: all registers 0, mmo_readdata=0, disp_valid=0, irq=0, FIFO empty; async assert, sync release by clk.
//  Map (word addr): 0 ID RO | 1 CTRL RW | 2 STATUS | 3 RELOAD RW | 4 COUNT RO | 5 SCORE RW |
//   6 SCORE_ADD WO | 7 DISP_PUSH WO. Addr 8..31 and WO regs read 0; writes to RO/unmapped ignored.
//  CTRL: [0] tmr_en, [1] auto_reload, [2] irq_en, [3] flush (self-clearing, reads 0). Others read 0.
//  STATUS: [0] tick W1C, [1] fifo_empty RO, [2] fifo_full RO, [3] overflow W1C, [8+FIFO_AW:8] level RO.
//  Read: mmo_readdata registered; value sampled in cycle of mmo_read, held until next read.
//  Read+write same cycle: write takes effect; readdata returns pre-write value.
//  Byteenable merges lanes on CTRL/RELOAD/SCORE; SCORE_ADD and DISP_PUSH ignore byteenable.
//  RELOAD write: RELOAD and COUNT both load merged value next cycle.
//  Timer: tmr_en=1 and COUNT!=0 -> COUNT-=1 per cycle. tmr_en=1 and COUNT==0 -> tick<=1;
//   auto_reload=1 -> COUNT<=RELOAD; else tmr_en<=0, COUNT stays 0. tmr_en=0 -> COUNT holds.
//  Tick set and tick W1C same cycle: set wins. RELOAD write same cycle as expiry: write wins, tick still set.
//  SCORE_ADD: SCORE<=min(SCORE+writedata, 32'hFFFFFFFF) (33-bit sum, saturate on carry).
//  FIFO: pop when disp_valid&&disp_ready; DISP_PUSH accepted if !full or pop same cycle; else word dropped,
//   overflow<=1. Push on empty: disp_valid rises next cycle. Pointers wrap mod depth; level 0..depth.
//  Flush: FIFO emptied next cycle; a push or pop in the flush cycle is discarded, no overflow.
//  Reset mid-operation: FIFO contents lost, timer stopped, no spurious disp_valid.
// CONFIGURATION
//  GAME_IRQ_EN defined: irq port exists; irq = irq_en & (tick | overflow), registered (1-cycle lag).
//  GAME_IRQ_EN undefined: irq port absent; CTRL[2] is storage-only (RW, no effect).
// TESTING
//  Reset then read addr 0 -> readdata 32'h47414D45 one cycle later; read addr 2 -> 32'h00000002.
//  RELOAD=3, CTRL=3 -> COUNT 3,2,1,0,3...; tick sets on 0; W1C STATUS=1 in expiry cycle -> tick stays 1.
//  RELOAD=2, CTRL=1 -> single expiry, CTRL[0] reads 0, COUNT 0 held.
//  SCORE=32'hFFFFFFF0, SCORE_ADD 32'h20 -> SCORE 32'hFFFFFFFF; SCORE byteenable 4'b0001 data 0 -> 32'hFFFFFF00.
//  disp_ready=0, push 9 words -> full, level 8, overflow=1; ready=1 -> words 1..8 in order, valid drops.
//  Full FIFO, push with pop same cycle -> accepted, no overflow; CTRL=8 -> empty next cycle.

Source files
------------

// File: rtl/mmo_game_regs.sv
// mmo_game_regs: Avalon-MM register block for the game SoC (single-cycle access, read latency 1).
// Holds ID, CTRL/STATUS, a down-counting game-tick timer, a saturating score and a display FIFO
// that fabric-side logic drains through a valid/ready handshake.
// Optional feature macro: GAME_IRQ_EN adds the registered irq output.
module mmo_game_regs #(
  parameter int          FIFO_AW  = 3,
  parameter logic [31:0] ID_VALUE = 32'h47414D45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmo_write,
  input  logic        mmo_read,
  input  logic [4:0]  mmo_address,
  input  logic [31:0] mmo_writedata,
  input  logic [3:0]  mmo_byteenable,
  output logic [31:0] mmo_readdata,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  input  logic        disp_ready
`ifdef GAME_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [4:0] A_ID     = 5'd0;
  localparam logic [4:0] A_CTRL   = 5'd1;
  localparam logic [4:0] A_STATUS = 5'd2;
  localparam logic [4:0] A_RELOAD = 5'd3;
  localparam logic [4:0] A_COUNT  = 5'd4;
  localparam logic [4:0] A_SCORE  = 5'd5;
  localparam logic [4:0] A_SADD   = 5'd6;
  localparam logic [4:0] A_PUSH   = 5'd7;

  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

  // Replace only the byte lanes that are enabled.
  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // 33-bit add that clamps to all-ones when the carry is set.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic                 tmr_en_q, tmr_en_d, auto_rl_q, auto_rl_d, irq_en_q, irq_en_d;
  logic                 tick_q, tick_d, ovf_q, ovf_d;
  logic [31:0]          reload_q, reload_d, count_q, count_d, score_q, score_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [31:0]          mem [DEPTH];

  logic wr_ctrl, wr_status, wr_reload, wr_score, wr_sadd, wr_push;
  logic flush, full, empty, pop, push_req, push, tick_set;
  logic [31:0] status, rd_mux;

  assign wr_ctrl   = mmo_write && (mmo_address == A_CTRL);
  assign wr_status = mmo_write && (mmo_address == A_STATUS);
  assign wr_reload = mmo_write && (mmo_address == A_RELOAD);
  assign wr_score  = mmo_write && (mmo_address == A_SCORE);
  assign wr_sadd   = mmo_write && (mmo_address == A_SADD);
  assign wr_push   = mmo_write && (mmo_address == A_PUSH);

  // Flush lives in CTRL lane 0 and is never stored.
  assign flush    = wr_ctrl && mmo_byteenable[0] && mmo_writedata[3];
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign pop      = !empty && disp_ready && !flush;
  assign push_req = wr_push && !flush;
  assign push     = push_req && (!full || pop);

  assign disp_valid   = !empty;
  assign disp_data    = mem[rd_ptr_q];
  assign mmo_readdata = rdata_q;

  // Read mux: STATUS assembled from sticky flags and FIFO level.
  always_comb begin
    status              = '0;
    status[0]           = tick_q;
    status[1]           = empty;
    status[2]           = full;
    status[3]           = ovf_q;
    status[8 +: FIFO_AW+1] = level_q;
    rd_mux = '0;
    case (mmo_address)
      A_ID:     rd_mux = ID_VALUE;
      A_CTRL:   rd_mux = {29'd0, irq_en_q, auto_rl_q, tmr_en_q};
      A_STATUS: rd_mux = status;
      A_RELOAD: rd_mux = reload_q;
      A_COUNT:  rd_mux = count_q;
      A_SCORE:  rd_mux = score_q;
      default:  rd_mux = '0;
    endcase
  end

  // Next-state for timer, flags, score, FIFO pointers and read data.
  always_comb begin
    tmr_en_d = tmr_en_q;
    auto_rl_d = auto_rl_q;
    irq_en_d = irq_en_q;
    reload_d = reload_q;
    count_d  = count_q;
    score_d  = score_q;
    tick_set = 1'b0;
    tick_d   = tick_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;

    if (tmr_en_q) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        tick_set = 1'b1;
        if (auto_rl_q) count_d = reload_q;
        else           tmr_en_d = 1'b0;
      end
    end
    if (wr_ctrl && mmo_byteenable[0]) begin
      tmr_en_d  = mmo_writedata[0];
      auto_rl_d = mmo_writedata[1];
      irq_en_d  = mmo_writedata[2];
    end
    // A RELOAD write overrides whatever the timer did this cycle.
    if (wr_reload) begin
      reload_d = merge_be(reload_q, mmo_writedata, mmo_byteenable);
      count_d  = reload_d;
    end

    if (wr_status && mmo_writedata[0]) tick_d = 1'b0;
    if (tick_set)                      tick_d = 1'b1;
    if (wr_status && mmo_writedata[3]) ovf_d = 1'b0;
    if (push_req && !push)             ovf_d = 1'b1;

    if (wr_score)     score_d = merge_be(score_q, mmo_writedata, mmo_byteenable);
    else if (wr_sadd) score_d = sat_add(score_q, mmo_writedata);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end

    if (mmo_read) rdata_d = rd_mux;
  end

  // Control and register state, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_en_q <= 1'b0;
      auto_rl_q <= 1'b0;
      irq_en_q <= 1'b0;
      tick_q   <= 1'b0;
      ovf_q    <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      score_q  <= '0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      tmr_en_q <= tmr_en_d;
      auto_rl_q <= auto_rl_d;
      irq_en_q <= irq_en_d;
      tick_q   <= tick_d;
      ovf_q    <= ovf_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      score_q  <= score_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage: contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= mmo_writedata;
  end

`ifdef GAME_IRQ_EN
  logic irq_q;
  // Interrupt registered from the sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_en_q && (tick_q || ovf_q);
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmo_game_regs.sv
// Scoreboard bench for mmo_game_regs: reads and display words are queued with their expected values
// when issued; monitors compare when read data or a display handshake appears.
module tb_mmo_game_regs;
  localparam logic [31:0] ID = 32'h47414D45;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mmo_write = 1'b0, mmo_read = 1'b0;
  logic [4:0]  mmo_address = '0;
  logic [31:0] mmo_writedata = '0;
  logic [3:0]  mmo_byteenable = 4'hF;
  logic [31:0] mmo_readdata, disp_data;
  logic        disp_valid;
  logic        disp_ready = 1'b0;
`ifdef GAME_IRQ_EN
  logic        irq;
`endif

  mmo_game_regs dut (
    .clk(clk), .reset(reset), .mmo_write(mmo_write), .mmo_read(mmo_read),
    .mmo_address(mmo_address), .mmo_writedata(mmo_writedata), .mmo_byteenable(mmo_byteenable),
    .mmo_readdata(mmo_readdata), .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_ready(disp_ready)
`ifdef GAME_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [31:0] disp_exp_q[$];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_e, d_e;
  string       rd_n;

  always @(posedge clk) rd_pend <= mmo_read;

  // Read monitor: data is valid in the cycle after the strobe.
  always @(negedge clk) begin
    if (rd_pend) begin
      total++;
      if (rd_exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got=%h want=<no read queued>", mmo_readdata);
      end else begin
        rd_e = rd_exp_q.pop_front();
        rd_n = rd_name_q.pop_front();
        if (mmo_readdata !== rd_e) begin
          bad++;
          $display("FAIL %s: got=%h want=%h", rd_n, mmo_readdata, rd_e);
        end
      end
    end
  end

  // Display monitor: compares each accepted word against the queued order.
  always @(posedge clk) begin
    if (!reset && disp_valid && disp_ready) begin
      total++;
      if (disp_exp_q.size() == 0) begin
        bad++;
        $display("FAIL disp_unexpected: got=%h want=<no word queued>", disp_data);
      end else begin
        d_e = disp_exp_q.pop_front();
        if (disp_data !== d_e) begin
          bad++;
          $display("FAIL disp_word: got=%h want=%h", disp_data, d_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    mmo_write = 1'b1; mmo_address = a; mmo_writedata = d; mmo_byteenable = be;
    @(negedge clk);
    mmo_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    mmo_read = 1'b1; mmo_address = a;
    rd_exp_q.push_back(exp); rd_name_q.push_back(name);
    @(negedge clk);
    mmo_read = 1'b0;
  endtask

  task automatic rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    mmo_read = 1'b1; mmo_write = 1'b1; mmo_address = a; mmo_writedata = d; mmo_byteenable = 4'hF;
    rd_exp_q.push_back(exp); rd_name_q.push_back(name);
    @(negedge clk);
    mmo_read = 1'b0; mmo_write = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    disp_exp_q.push_back(d);
    wr(5'd7, d, 4'hF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_readdata", mmo_readdata, 32'h0);
    chk("rst_disp_valid", {31'd0, disp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // ID and reset values
    rd(5'd0, ID, "id");
    rd(5'd2, 32'h2, "status_rst");
    rd(5'd1, 32'h0, "ctrl_rst");
    rd(5'd4, 32'h0, "count_rst");

    // Auto-reload timer: 3,2,1,0,3 then W1C in expiry cycle loses to the set
    wr(5'd3, 32'd3, 4'hF);
    wr(5'd1, 32'd3, 4'hF);
    rd(5'd4, 32'd3, "count_a3");
    rd(5'd4, 32'd2, "count_a2");
    rd(5'd4, 32'd1, "count_a1");
    rd(5'd4, 32'd0, "count_a0");
    rd(5'd4, 32'd3, "count_reloaded");
    wr(5'd2, 32'h1, 4'hF);
    rd(5'd2, 32'h2, "tick_cleared");
    wr(5'd2, 32'h1, 4'hF);
    rd(5'd2, 32'h3, "tick_set_wins");
    wr(5'd1, 32'h0, 4'hF);
    wr(5'd2, 32'h1, 4'hF);

    // One-shot timer: stops itself, COUNT held at 0
    wr(5'd3, 32'd2, 4'hF);
    wr(5'd1, 32'd1, 4'hF);
    repeat (3) @(negedge clk);
    rd(5'd1, 32'h0, "oneshot_ctrl");
    rd(5'd4, 32'h0, "oneshot_count");
    rd(5'd2, 32'h3, "oneshot_tick");
    rd(5'd3, 32'd2, "reload_rb");
    wr(5'd2, 32'h1, 4'hF);

    // Score: saturation, lane merge, byteenable ignored on add, read+write
    wr(5'd5, 32'hFFFF_FFF0, 4'hF);
    wr(5'd6, 32'h20, 4'hF);
    rd(5'd5, 32'hFFFF_FFFF, "score_sat");
    wr(5'd5, 32'h0, 4'b0001);
    rd(5'd5, 32'hFFFF_FF00, "score_lane0");
    wr(5'd6, 32'h5, 4'b0000);
    rd(5'd5, 32'hFFFF_FF05, "score_add");
    rw(5'd5, 32'h1234, 32'hFFFF_FF05, "rw_prewrite");
    rd(5'd5, 32'h1234, "rw_postwrite");

    // Unmapped / write-only / read-only
    wr(5'd0, 32'hDEAD_BEEF, 4'hF);
    rd(5'd0, ID, "id_ro");
    rd(5'd6, 32'h0, "sadd_wo");
    rd(5'd7, 32'h0, "push_wo");
    rd(5'd8, 32'h0, "unmapped8");
    rd(5'd31, 32'h0, "unmapped31");

    // FIFO overflow and drain
    disp_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(i);
    wr(5'd7, 32'd9, 4'hF);
    rd(5'd2, 32'h80C, "fifo_full_ovf");
    disp_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drained_valid", {31'd0, disp_valid}, 32'h0);
    rd(5'd2, 32'h00A, "drained_status");
    wr(5'd2, 32'h8, 4'hF);
    rd(5'd2, 32'h2, "ovf_cleared");

    // Full FIFO: push with simultaneous pop accepted, then flush
    disp_ready = 1'b0;
    for (int i = 10; i <= 17; i++) push(i);
    disp_ready = 1'b1;
    push(32'd18);
    disp_ready = 1'b0;
    rd(5'd2, 32'h804, "push_pop_full");
    disp_exp_q.delete();
    wr(5'd1, 32'h8, 4'hF);
    rd(5'd2, 32'h2, "flush_empty");
    rd(5'd1, 32'h0, "flush_reads0");
    chk("flush_valid", {31'd0, disp_valid}, 32'h0);
    push(32'hAB);
    chk("push_empty_valid", {31'd0, disp_valid}, 32'h1);
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    @(negedge clk);

    // Reset mid-operation
    wr(5'd3, 32'd5, 4'hF);
    wr(5'd1, 32'd1, 4'hF);
    wr(5'd7, 32'h55, 4'hF);
    wr(5'd7, 32'h66, 4'hF);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", {31'd0, disp_valid}, 32'h0);
    chk("midrst_readdata", mmo_readdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, disp_valid}, 32'h0);
    rd(5'd2, 32'h2, "post_rst_status");
    rd(5'd4, 32'h0, "post_rst_count");
    rd(5'd1, 32'h0, "post_rst_ctrl");
    repeat (3) @(negedge clk);

    chk("rd_queue_left", rd_exp_q.size(), 32'h0);
    chk("disp_queue_left", disp_exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
